dm_responder: RTL and testbench

//   Data-memory responder on the far side of the M-stage load/store port.

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_byte_lane.sv | 50 +++++
 rtl/dm_responder.sv | 156 +++++++++++++++
 tb/tb_dm_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and FSM state encoding.
package dm_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dm_byte_lane.sv
// Little-endian lane steering: store byte enables / replicated write word, and load extraction with extension.
module dm_byte_lane
    import dm_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic        sign_ext,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_shift = rword >> {lane, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = lane[1] ? rword[31:16] : rword[15:0];

    // Write data is replicated across lanes so byte_en alone picks the target bytes.
    always_comb begin
        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = '0;
        case (size)
            SIZE_BYTE: begin
                byte_en = 4'b0001 << lane;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{sign_ext & rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = {{16{sign_ext & rd_half[15]}}, rd_half};
            end
            SIZE_WORD: begin
                byte_en = 4'b1111;
                rdata   = rword;
            end
            default: begin
                byte_en = 4'b0000;
                rdata   = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one load/store per request with configurable wait states and error reporting.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for Req; accepts, checks and latches the request
//   ST_WAIT | counting wait states; commits when the counter reaches 1
//   ST_DONE | Ready high for one cycle, RData/AddrErr valid
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        We,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    output logic        Ready,
    output logic [31:0] RData,
    output logic        AddrErr,
    output logic        Busy
);

    localparam int          DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

    state_t state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] mem [DEPTH];

    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [1:0]            acc_size;
    logic                  acc_sext;
    logic [31:0]           acc_off;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  req_err;
    logic                  accept;
    logic                  commit;
    logic                  err_edge;
    logic [3:0]            byte_en;
    logic [31:0]           wword;
    logic [31:0]           ld_data;

    // A zero-wait access commits on the accepting edge, before the latches hold anything.
    assign acc_we    = (state == ST_IDLE) ? We      : we_q;
    assign acc_addr  = (state == ST_IDLE) ? Addr    : addr_q;
    assign acc_wdata = (state == ST_IDLE) ? WData   : wdata_q;
    assign acc_size  = (state == ST_IDLE) ? Size    : size_q;
    assign acc_sext  = (state == ST_IDLE) ? SignExt : sext_q;

    assign acc_off = acc_addr - BASE_ADDR;
    assign acc_idx = acc_off[ADDR_WIDTH+1:2];

    assign req_err = (acc_size == SIZE_RSVD)
                   | ((acc_size == SIZE_HALF) & acc_addr[0])
                   | ((acc_size == SIZE_WORD) & (|acc_addr[1:0]))
                   | ({1'b0, acc_off} >= MEM_BYTES);

    dm_byte_lane u_lane (
        .lane     (acc_addr[1:0]),
        .size     (acc_size),
        .wdata    (acc_wdata),
        .sign_ext (acc_sext),
        .rword    (mem[acc_idx]),
        .byte_en  (byte_en),
        .wword    (wword),
        .rdata    (ld_data)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        err_edge  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    accept = 1'b1;
                    if (req_err) begin
                        err_edge  = 1'b1;
                        state_nxt = ST_DONE;
                    end else if (WAIT_CYCLES == 0) begin
                        commit    = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    commit    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            RData    <= '0;
            AddrErr  <= 1'b0;
            mem      <= '{default: '0};
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q     <= We;
                addr_q   <= Addr;
                wdata_q  <= WData;
                size_q   <= Size;
                sext_q   <= SignExt;
                wait_cnt <= WAIT_LD;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (err_edge) begin
                RData   <= '0;
                AddrErr <= 1'b1;
            end else if (commit) begin
                AddrErr <= 1'b0;
                RData   <= acc_we ? 32'h0 : ld_data;
                if (acc_we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_en[i]) mem[acc_idx][8*i +: 8] <= wword[8*i +: 8];
                    end
                end
            end
        end
    end

    assign Ready = (state == ST_DONE);
    assign Busy  = Req & ~Ready;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed load/store/error/reset steps plus random accesses against a byte-level model.
module tb_dm_responder;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          AW        = 12;
    localparam int          MEM_BYTES = 4 * (2 ** AW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, req_a, we_a, sext_a, ready_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [1:0]  size_a;
    logic        reset_b, req_b, we_b, sext_b, ready_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [1:0]  size_b;

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_a (
        .Clk(clk), .Reset(reset_a), .Req(req_a), .We(we_a), .Addr(addr_a), .WData(wdata_a),
        .Size(size_a), .SignExt(sext_a), .Ready(ready_a), .RData(rdata_a), .AddrErr(err_a), .Busy(busy_a)
    );

    dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut_b (
        .Clk(clk), .Reset(reset_b), .Req(req_b), .We(we_b), .Addr(addr_b), .WData(wdata_b),
        .Size(size_b), .SignExt(sext_b), .Ready(ready_b), .RData(rdata_b), .AddrErr(err_b), .Busy(busy_b)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [7:0] mb [MEM_BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
    endtask

    // Byte-addressed memory; an access touches nb consecutive bytes, lowest address least significant.
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic sext,
                                output logic [31:0] rd, output logic err);
        int nb;
        int base_i;
        logic [31:0] off;
        logic [31:0] v;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = addr - BASE;
        err = (size == 2'd3) || ((addr % nb) != 0) || (off >= MEM_BYTES);
        rd  = 32'h0;
        if (!err) begin
            base_i = int'(off);
            if (we) begin
                for (int i = 0; i < nb; i++) mb[base_i + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(mb[base_i + i]) << (8 * i));
                if (sext && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
                rd = v;
            end
        end
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sext,
                          output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        model_access(we, addr, wdata, size, sext, exp_rd, exp_err);
        req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; size_a = size; sext_a = sext;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!ready_a) check("busy_stall", 32'(busy_a), 32'd1);
        end while (!ready_a && lat < 20);
        check("latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
        check("busy_at_ready", 32'(busy_a), 32'd0);
        check("addr_err", 32'(err_a), 32'(exp_err));
        check("rdata", rdata_a, exp_rd);
        rd  = rdata_a;
        err = err_a;
        req_a = 1'b0;
        @(posedge clk); #1;
        check("ready_single", 32'(ready_a), 32'd0);
        check("rdata_hold", rdata_a, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] a;
        int          pulses;

        reset_a = 1'b1; req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; size_a = '0; sext_a = 1'b0;
        reset_b = 1'b1; req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; size_b = '0; sext_b = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_b_ready", 32'(ready_b), 32'd0);
        check("rst_b_rdata", rdata_b, 32'h0);
        reset_a = 1'b0;
        reset_b = 1'b0;

        access(1'b1, 32'h10, 32'h89AB_CDEF, 2'b10, 1'b0, rd, err);
        check("t1_sw_err", 32'(err), 32'd0);
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, err);
        check("t1_lw", rd, 32'h89AB_CDEF);

        access(1'b1, 32'h13, 32'h0000_0055, 2'b00, 1'b0, rd, err);
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, err);
        check("t2_lw", rd, 32'h55AB_CDEF);
        access(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, err);
        check("t2_lb13", rd, 32'h0000_0055);
        access(1'b0, 32'h12, 32'h0, 2'b00, 1'b1, rd, err);
        check("t2_lb12", rd, 32'hFFFF_FFAB);
        access(1'b0, 32'h12, 32'h0, 2'b00, 1'b0, rd, err);
        check("t2_lbu12", rd, 32'h0000_00AB);

        access(1'b1, 32'h12, 32'h0000_8001, 2'b01, 1'b0, rd, err);
        access(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, err);
        check("t3_lh", rd, 32'hFFFF_8001);
        access(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, err);
        check("t3_lhu", rd, 32'h0000_8001);
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, err);
        check("t3_lw", rd, 32'h8001_CDEF);

        access(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, err);
        check("t4_lw_mis_err", 32'(err), 32'd1);
        check("t4_lw_mis_rd", rd, 32'h0);
        access(1'b1, 32'h13, 32'h0000_FFFF, 2'b01, 1'b0, rd, err);
        check("t4_sh_mis_err", 32'(err), 32'd1);
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, err);
        check("t4_mem_intact", rd, 32'h8001_CDEF);
        access(1'b1, 32'h4000, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, err);
        check("t4_sw_range_err", 32'(err), 32'd1);
        access(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, err);
        check("t4_rsvd_err", 32'(err), 32'd1);

        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'h1234_5678; size_a = 2'b10; sext_a = 1'b0;
        @(posedge clk); #1;
        check("t5_wait_busy", 32'(busy_a), 32'd1);
        check("t5_wait_ready", 32'(ready_a), 32'd0);
        reset_a = 1'b1;
        @(posedge clk); #1;
        check("t5_rst_ready", 32'(ready_a), 32'd0);
        check("t5_rst_busy", 32'(busy_a), 32'd1);
        reset_a = 1'b0;
        req_a = 1'b0;
        model_clear();
        @(posedge clk); #1;
        check("t5_no_pulse", 32'(ready_a), 32'd0);
        access(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, err);
        check("t5_lw20", rd, 32'h0);
        access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, err);
        check("t5_lw10_cleared", rd, 32'h0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'h4000 + 32'($urandom_range(0, 255)) : 32'hFFFF_FFFC;
            else
                a = 32'($urandom_range(0, 63));
            access(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), rd, err);
        end

        req_b = 1'b1; we_b = 1'b1; addr_b = 32'h40; wdata_b = 32'hCAFE_F00D; size_b = 2'b10;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("t6_ready", 32'(ready_b), 32'(k % 2));
            check("t6_busy", 32'(busy_b), 32'((k + 1) % 2));
            if (ready_b) begin
                check("t6_err", 32'(err_b), 32'd0);
                pulses++;
            end
        end
        req_b = 1'b0;
        check("t6_pulses", 32'(pulses), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
